pattern_capture_ctrl: RTL and testbench

Sequencer for the digital pattern generator/analyzer pair. It arms the generator on a start request and holds off for a programmable pre-trigger interval. It then waits for a masked trigger condition on the generated pattern, enables the analyzer for a programmable capture window, and counts cycles with `match_detected` high. It sits between the host/control registers and the pattern generator/analyzer datapath, and reports completion, trigger, timeout and abort status.

---
 rtl/pattern_capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_pattern_capture_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_capture_ctrl.sv
// Capture-run sequencer: arms the pattern generator, waits for a masked
// trigger, then gates the analyzer for a capture window and counts matches.
module pattern_capture_ctrl #(
    parameter int WIDTH   = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [CNT_W-1:0] pretrig_len,
    input  logic [CNT_W-1:0] capture_len,
    input  logic [WIDTH-1:0] gen_patterns,
    input  logic             match_detected,
    output logic             gen_enable,
    output logic             analyzer_enable,
    output logic             busy,
    output logic             done,
    output logic             triggered,
    output logic             timed_out,
    output logic             aborted,
    output logic [CNT_W-1:0] match_count
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT, S_CAP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CNT_W-1:0] arm_q, arm_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic             trig_q, trig_d;
    logic             tout_q, tout_d;
    logic             abrt_q, abrt_d;
    logic             hit;

    assign hit = ((gen_patterns ^ value_q) & mask_q) == '0;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        value_d = value_q;
        arm_d   = arm_q;
        cap_d   = cap_q;
        to_d    = to_q;
        match_d = match_q;
        trig_d  = trig_q;
        tout_d  = tout_q;
        abrt_d  = abrt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = trig_mask;
                    value_d = trig_value;
                    cap_d   = (capture_len == '0) ? CNT_W'(1) : capture_len;
                    arm_d   = pretrig_len;
                    to_d    = '0;
                    match_d = '0;
                    trig_d  = 1'b0;
                    tout_d  = 1'b0;
                    abrt_d  = 1'b0;
                    state_d = (pretrig_len != '0) ? S_ARM : S_WAIT;
                end
            end
            S_ARM: begin
                if (abort) begin
                    abrt_d  = 1'b1;
                    state_d = S_DONE;
                end else if (arm_q <= CNT_W'(1)) begin
                    state_d = S_WAIT;
                end else begin
                    arm_d = arm_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    abrt_d  = 1'b1;
                    state_d = S_DONE;
                end else if (hit) begin
                    trig_d  = 1'b1;
                    state_d = S_CAP;
                end else if (to_q == TO_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_CAP: begin
                if (abort) begin
                    abrt_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // saturate rather than wrap
                    if (match_detected && match_q != '1)
                        match_d = match_q + 1'b1;
                    if (cap_q <= CNT_W'(1))
                        state_d = S_DONE;
                    else
                        cap_d = cap_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            value_q <= '0;
            arm_q   <= '0;
            cap_q   <= '0;
            to_q    <= '0;
            match_q <= '0;
            trig_q  <= 1'b0;
            tout_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            value_q <= value_d;
            arm_q   <= arm_d;
            cap_q   <= cap_d;
            to_q    <= to_d;
            match_q <= match_d;
            trig_q  <= trig_d;
            tout_q  <= tout_d;
            abrt_q  <= abrt_d;
        end
    end

    assign busy            = state_q inside {S_ARM, S_WAIT, S_CAP};
    assign gen_enable      = busy;
    assign analyzer_enable = state_q == S_CAP;
    assign done            = state_q == S_DONE;
    assign triggered       = trig_q;
    assign timed_out       = tout_q;
    assign aborted         = abrt_q;
    assign match_count     = match_q;

endmodule

// File: tb/tb_pattern_capture_ctrl.sv
// Directed bench for pattern_capture_ctrl (WIDTH=3, CNT_W=4, TIMEOUT=5).
// Index i in each loop = stimulus sampled at edge Ei, outputs read after Ei.
module tb_pattern_capture_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] trig_mask = '0;
    logic [2:0] trig_value = '0;
    logic [3:0] pretrig_len = '0;
    logic [3:0] capture_len = '0;
    logic [2:0] gen_patterns = '0;
    logic       match_detected = 1'b0;
    logic       gen_enable, analyzer_enable, busy, done;
    logic       triggered, timed_out, aborted;
    logic [3:0] match_count;

    int n_cmp = 0;
    int n_err = 0;
    int gen_c, an_c, done_c, busy_c, done_at;

    pattern_capture_ctrl #(.WIDTH(3), .CNT_W(4), .TIMEOUT(5)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value),
        .pretrig_len(pretrig_len), .capture_len(capture_len),
        .gen_patterns(gen_patterns), .match_detected(match_detected),
        .gen_enable(gen_enable), .analyzer_enable(analyzer_enable),
        .busy(busy), .done(done), .triggered(triggered),
        .timed_out(timed_out), .aborted(aborted),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        gen_c = 0; an_c = 0; done_c = 0; busy_c = 0; done_at = -1;
    endtask

    task automatic step(input int i);
        @(posedge clk);
        #1;
        gen_c  += int'(gen_enable);
        an_c   += int'(analyzer_enable);
        busy_c += int'(busy);
        if (done) begin
            done_c++;
            done_at = i;
        end
    endtask

    task automatic setup(input logic [2:0] m, input logic [2:0] v,
                         input logic [3:0] p, input logic [3:0] c);
        trig_mask = m; trig_value = v; pretrig_len = p; capture_len = c;
        clr();
    endtask

    function automatic int stat();
        return int'({gen_enable, analyzer_enable, busy, done,
                     triggered, timed_out, aborted, match_count});
    endfunction

    initial begin
        #3;
        check("reset_outputs", stat(), 0);
        #10 reset = 1'b1;

        // basic run
        setup(3'b111, 3'b101, 4'd2, 4'd4);
        for (int i = 0; i < 12; i++) begin
            start = (i == 0);
            gen_patterns = (i >= 3) ? 3'b101 : 3'b000;
            match_detected = (i == 4 || i == 5 || i == 7);
            step(i);
        end
        check("basic_gen_cycles", gen_c, 7);
        check("basic_an_cycles", an_c, 4);
        check("basic_done_count", done_c, 1);
        check("basic_done_at", done_at, 7);
        check("basic_match_count", match_count, 3);
        check("basic_triggered", triggered, 1);
        check("basic_idle_flags", {busy, timed_out, aborted}, 0);

        // immediate trigger, capture_len 0 acts as 1
        setup(3'b000, 3'b000, 4'd0, 4'd0);
        match_detected = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            step(i);
        end
        check("imm_done_at", done_at, 2);
        check("imm_an_cycles", an_c, 1);
        check("imm_busy_cycles", busy_c, 2);
        check("imm_triggered", triggered, 1);

        // timeout after 5 WAIT_TRIG cycles
        setup(3'b111, 3'b000, 4'd0, 4'd3);
        gen_patterns = 3'b111;
        for (int i = 0; i < 9; i++) begin
            start = (i == 0);
            step(i);
        end
        check("to_done_at", done_at, 5);
        check("to_busy_cycles", busy_c, 5);
        check("to_timed_out", timed_out, 1);
        check("to_triggered", triggered, 0);
        check("to_an_cycles", an_c, 0);

        // abort after 4 capture cycles
        setup(3'b000, 3'b000, 4'd1, 4'd10);
        match_detected = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 0);
            abort = (i == 7);
            step(i);
        end
        abort = 1'b0;
        check("abc_match_count", match_count, 4);
        check("abc_aborted", aborted, 1);
        check("abc_done_at", done_at, 7);
        check("abc_an_cycles", an_c, 5);
        check("abc_timed_out", timed_out, 0);

        // abort coincident with trigger hit; stray starts ignored
        setup(3'b111, 3'b010, 4'd2, 4'd3);
        gen_patterns = 3'b010;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0 || i == 2 || i == 4);
            abort = (i == 3);
            step(i);
        end
        start = 1'b0;
        abort = 1'b0;
        check("abt_done_at", done_at, 3);
        check("abt_done_count", done_c, 1);
        check("abt_busy_cycles", busy_c, 3);
        check("abt_aborted", aborted, 1);
        check("abt_triggered", triggered, 0);
        check("abt_an_cycles", an_c, 0);
        check("abt_match_count", match_count, 0);

        // full-width window, matches every cycle
        setup(3'b000, 3'b000, 4'd0, 4'd15);
        match_detected = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = (i == 0);
            step(i);
        end
        check("sat_match_count", match_count, 15);
        check("sat_an_cycles", an_c, 15);
        check("sat_aborted_cleared", aborted, 0);

        // reset mid-run
        setup(3'b000, 3'b000, 4'd0, 4'd15);
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            step(i);
        end
        start = 1'b0;
        check("rst_pre_match", match_count, 2);
        #2 reset = 1'b0;
        #1;
        check("rst_outputs_now", stat(), 0);
        clr();
        for (int i = 0; i < 3; i++) step(i);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(i);
        check("rst_no_done", done_c, 0);
        check("rst_no_busy", busy_c, 0);
        check("rst_outputs_after", stat(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
